usbh_report_decoder_nes_multi: RTL and testbench
================================================

// Module: usbh_report_decoder_nes_multi
// PURPOSE
//  Multi-player successor of the NES USB joystick HID decoder. Sits after the USB host core, same clock domain.
//  Decodes each player's 64-bit HID report into NES 8-bit button state: {R,L,D,U,Start,Select,B,A}.
//  Adds the following over the single-player decoder:
//   - per-player routing;
//   - chord qualification over consecutive reports;
//   - a disconnect timeout;
//   - an optional A/B autofire.
// PARAMETERS
//  c_clk_hz         6000000  clock frequency, Hz
//  c_players        2        number of players/channels, 1..4
//  c_autofire_hz    10       autofire press rate, Hz (full on/off period)
//  c_timeout_ms     100      report silence before a player is marked absent
//  c_chord_reports  2        consecutive chord reports (A+B+Start+Select) needed to force all directions
// PORTS
//  i_clk           in   1               USB core clock
//  i_rst_n         in   1               async active-low reset
//  i_report        in   64              HID report
//  i_report_valid  in   1               one-cycle qualifier for i_report
//  i_report_player in   2               player index of the current report
//  i_autofire_en   in   2*c_players     per player {B,A} autofire enable; bit 2p = A, bit 2p+1 = B
//  o_btn           out  8*c_players     button state, player p at [8p+:8]
//  o_btn_strobe    out  1               one-cycle pulse: o_btn of o_btn_player updated
//  o_btn_player    out  2               player index of the last update
//  o_present       out  c_players       player has reported within the timeout
// BEHAVIOUR
//  Reset: all outputs 0; counters 0; autofire phase 0. The async assert takes effect mid-report; the pending decode is discarded.
//  Field map (fixed):
//   - L = [31:30]==00, R = [31:30]==11;
//   - U = [39:38]==00, D = [39:38]==11;
//   - A = [45], B = [44], Start = [53], Select = [52].
//  Report acceptance:
//   - A report is accepted when i_report_valid=1 and i_report_player<c_players; others are ignored entirely (no strobe, no timer reset).
//   - Latency 1: the decoded byte is in o_btn, with o_btn_strobe=1 and o_btn_player set, the cycle after accept. The strobe is never back-to-back for the same report.
//  Chord, per-player counter (saturating at c_chord_reports):
//   - increments on each accepted report where A,B,Start,Select are all 1;
//   - clears on any accepted report without the chord.
//   - When count>=c_chord_reports, that report's R,L,D,U outputs are forced to 1; the other bits are unchanged.
//  Timeout, per-player cycle counter, T = c_clk_hz/1000*c_timeout_ms:
//   - cleared by an accepted report; increments otherwise and saturates at T.
//   - On reaching T: o_btn[p] <= 0, o_present[p] <= 0, chord counter <= 0. No strobe is issued.
//   - An accept in the same cycle as expiry wins: the timer clears and the player stays present.
//   - o_present[p] <= 1 on every accept.
//  Accepts are single-ported; concurrent reports for different players cannot occur.
//  Width: the timer is $clog2(T+1) bits; the autofire divider is $clog2(c_clk_hz/(2*c_autofire_hz)) bits.
// CONFIGURATION
//  Macro USBH_NES_AUTOFIRE_EN.
//  Defined:
//   - A free-running phase toggles every c_clk_hz/(2*c_autofire_hz) cycles.
//   - For player p, an A/B output bit equals held & phase when i_autofire_en for that bit is 1.
//   - Stored state keeps the raw held bit; the gating is applied on the output path, so o_btn changes without a strobe.
//  Undefined:
//   - i_autofire_en is present but ignored; no divider is built.
//   - A/B outputs equal the raw held bits.
// STRUCTURE
//  Package usbh_nes_pkg:
//   - report bit-index constants (X_HI, Y_HI, BTN_A, BTN_B, BTN_START, BTN_SELECT);
//   - NES button bit positions;
//   - player index width.
//  One sub-module, usbh_autofire_tick (divider + phase), instanced only under USBH_NES_AUTOFIRE_EN.
//  Per-player state in generate loops.
// TESTING
//  Reset, then player-0 report with [45]=1, [31:30]=11 -> next cycle o_btn[7:0]=8'h81, strobe=1, player=0, o_present=2'b01.
//  Player-1 report with [39:38]=00, [53]=1 -> o_btn[15:8]=8'h18 and o_btn[7:0] unchanged; player=3 report with c_players=2 -> no strobe, no state change.
//  Two consecutive player-0 chord reports ([45],[44],[53],[52]=1, axes centred 01) -> 1st gives 8'h0F, 2nd gives 8'hFF; then a non-chord report -> count clears.
//  Timeout, with c_clk_hz=1000000, c_timeout_ms=1 -> T=1000: player 0 silent for 1000 cycles -> o_btn[7:0]=0, o_present[0]=0; a report landing on the expiry cycle keeps o_present=1.
//  USBH_NES_AUTOFIRE_EN, c_clk_hz=1000, c_autofire_hz=10, i_autofire_en=2'b01, A held -> o_btn[0] toggles every 50 cycles; without the macro o_btn[0] stays 1.
//  Assert i_rst_n=0 in the cycle after accept -> all outputs 0 immediately; no strobe after release.

Source files
------------

// File: rtl/usbh_report_decoder_nes_multi_pkg.sv
// Shared constants for the multi-player NES HID report decoder: report field
// positions, NES button bit order, player index width and the field decoder.
package usbh_nes_pkg;

  localparam int X_HI       = 31;
  localparam int Y_HI       = 39;
  localparam int BTN_A      = 45;
  localparam int BTN_B      = 44;
  localparam int BTN_START  = 53;
  localparam int BTN_SELECT = 52;

  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_U      = 4;
  localparam int NES_D      = 5;
  localparam int NES_L      = 6;
  localparam int NES_R      = 7;

  localparam int PLAYER_W   = 2;

  typedef logic [7:0] nes_btn_t;

  function automatic nes_btn_t nes_decode(input logic [63:0] rpt);
    nes_btn_t b;
    b             = 8'h00;
    b[NES_A]      = rpt[BTN_A];
    b[NES_B]      = rpt[BTN_B];
    b[NES_SELECT] = rpt[BTN_SELECT];
    b[NES_START]  = rpt[BTN_START];
    b[NES_L]      = (rpt[X_HI -: 2] == 2'b00);
    b[NES_R]      = (rpt[X_HI -: 2] == 2'b11);
    b[NES_U]      = (rpt[Y_HI -: 2] == 2'b00);
    b[NES_D]      = (rpt[Y_HI -: 2] == 2'b11);
    return b;
  endfunction

  function automatic logic is_chord(input logic [63:0] rpt);
    return rpt[BTN_A] & rpt[BTN_B] & rpt[BTN_START] & rpt[BTN_SELECT];
  endfunction

endpackage

// File: rtl/usbh_report_decoder_nes_multi_if.sv
// Report-in / button-state-out bundle of the multi-player NES decoder.
interface usbh_report_decoder_nes_multi_if #(parameter int c_players = 2);
  import usbh_nes_pkg::*;

  logic [63:0]            i_report;
  logic                   i_report_valid;
  logic [PLAYER_W-1:0]    i_report_player;
  logic [2*c_players-1:0] i_autofire_en;
  logic [8*c_players-1:0] o_btn;
  logic                   o_btn_strobe;
  logic [PLAYER_W-1:0]    o_btn_player;
  logic [c_players-1:0]   o_present;

  modport master (
    output i_report, i_report_valid, i_report_player, i_autofire_en,
    input  o_btn, o_btn_strobe, o_btn_player, o_present
  );

  modport slave (
    input  i_report, i_report_valid, i_report_player, i_autofire_en,
    output o_btn, o_btn_strobe, o_btn_player, o_present
  );

endinterface

// File: rtl/usbh_autofire_tick.sv
// Free-running autofire divider: o_phase toggles every c_div clock cycles.
module usbh_autofire_tick #(
  parameter int c_div = 300000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_phase
);

  localparam int c_w = (c_div > 1) ? $clog2(c_div) : 1;

  logic [c_w-1:0] cnt_r;
  logic           phase_r;

  // Divider count and phase toggle on wrap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (cnt_r == c_w'(c_div - 1)) begin
      cnt_r   <= '0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + c_w'(1);
      phase_r <= phase_r;
    end
  end

  assign o_phase = phase_r;

endmodule

// File: rtl/usbh_report_decoder_nes_multi.sv
// Multi-player NES HID report decoder with chord qualification and disconnect
// timeout. Define USBH_NES_AUTOFIRE_EN to build the A/B autofire gating.
module usbh_report_decoder_nes_multi
  import usbh_nes_pkg::*;
#(
  parameter int c_clk_hz        = 6000000,
  parameter int c_players       = 2,
  parameter int c_autofire_hz   = 10,
  parameter int c_timeout_ms    = 100,
  parameter int c_chord_reports = 2
) (
  input logic i_clk,
  input logic i_rst_n,
  usbh_report_decoder_nes_multi_if.slave bus
);

  localparam int c_timeout_t = c_clk_hz / 1000 * c_timeout_ms;
  localparam int c_tmr_w     = $clog2(c_timeout_t + 1);
  localparam int c_chord_w   = $clog2(c_chord_reports + 1);

  logic                accept_s;
  logic                chord_s;
  nes_btn_t            dec_s;
  logic                strobe_r;
  logic [PLAYER_W-1:0] player_r;
  logic                unused_s;

  assign accept_s = bus.i_report_valid && (32'(bus.i_report_player) < c_players);
  assign dec_s    = nes_decode(bus.i_report);
  assign chord_s  = is_chord(bus.i_report);
  assign unused_s = ^{bus.i_report, bus.i_autofire_en};

`ifdef USBH_NES_AUTOFIRE_EN
  logic phase_s;

  usbh_autofire_tick #(
    .c_div (c_clk_hz / (2 * c_autofire_hz))
  ) u_autofire_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_phase (phase_s)
  );
`endif

  // Shared update strobe and the player it refers to
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      strobe_r <= 1'b0;
      player_r <= '0;
    end else if (accept_s) begin
      strobe_r <= 1'b1;
      player_r <= bus.i_report_player;
    end else begin
      strobe_r <= 1'b0;
      player_r <= player_r;
    end
  end

  assign bus.o_btn_strobe = strobe_r;
  assign bus.o_btn_player = player_r;

  for (genvar p = 0; p < c_players; p++) begin : g_player
    logic                 hit_s;
    logic                 expire_s;
    logic [c_chord_w-1:0] chord_cnt_r;
    logic [c_chord_w-1:0] chord_nxt_s;
    logic [c_tmr_w-1:0]   tmr_r;
    nes_btn_t             btn_r;
    logic                 present_r;
    logic [1:0]           af_keep_s;

    assign hit_s    = accept_s && (bus.i_report_player == PLAYER_W'(p));
    // An accept on the expiry cycle wins, so expiry is only seen without a hit
    assign expire_s = !hit_s && (tmr_r == c_tmr_w'(c_timeout_t - 1));

    // Saturating count of consecutive chord reports
    always_comb begin
      chord_nxt_s = '0;
      if (!chord_s) begin
        chord_nxt_s = '0;
      end else if (chord_cnt_r >= c_chord_w'(c_chord_reports)) begin
        chord_nxt_s = chord_cnt_r;
      end else begin
        chord_nxt_s = chord_cnt_r + c_chord_w'(1);
      end
    end

    // Per-player held state, chord counter and silence timer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        tmr_r       <= '0;
        chord_cnt_r <= '0;
        btn_r       <= 8'h00;
        present_r   <= 1'b0;
      end else if (hit_s) begin
        tmr_r       <= '0;
        chord_cnt_r <= chord_nxt_s;
        present_r   <= 1'b1;
        if (chord_nxt_s >= c_chord_w'(c_chord_reports)) begin
          btn_r <= dec_s | 8'hF0;
        end else begin
          btn_r <= dec_s;
        end
      end else if (expire_s) begin
        tmr_r       <= tmr_r + c_tmr_w'(1);
        chord_cnt_r <= '0;
        btn_r       <= 8'h00;
        present_r   <= 1'b0;
      end else if (tmr_r != c_tmr_w'(c_timeout_t)) begin
        tmr_r       <= tmr_r + c_tmr_w'(1);
      end else begin
        tmr_r       <= tmr_r;
      end
    end

`ifdef USBH_NES_AUTOFIRE_EN
    assign af_keep_s = ~bus.i_autofire_en[2*p +: 2] | {2{phase_s}};
`else
    assign af_keep_s = 2'b11;
`endif

    assign bus.o_btn[8*p +: 8] = {btn_r[7:2], btn_r[1:0] & af_keep_s};
    assign bus.o_present[p]    = present_r;
  end

endmodule

// File: tb/tb_usbh_report_decoder_nes_multi.sv
// Randomized bench for usbh_report_decoder_nes_multi against a per-player
// behavioural model, plus literal expectations for the documented scenarios.
module tb_usbh_report_decoder_nes_multi;

  localparam int P   = 2;
  localparam int HZ  = 1000000;
  localparam int AHZ = 10;
  localparam int TMS = 1;
  localparam int C   = 2;
  localparam int T   = HZ / 1000 * TMS;
  localparam int DIV = HZ / (2 * AHZ);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  usbh_report_decoder_nes_multi_if #(.c_players(P)) bus();

  usbh_report_decoder_nes_multi #(
    .c_clk_hz(HZ), .c_players(P), .c_autofire_hz(AHZ),
    .c_timeout_ms(TMS), .c_chord_reports(C)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] m_held    [P];
  int         m_chord   [P];
  int         m_silent  [P];
  logic       m_present [P];
  logic       m_strobe;
  logic [1:0] m_player;
  longint     m_edges;

  function automatic logic [7:0] ref_decode(input logic [63:0] r);
    logic [1:0] x, y;
    x = r[31:30];
    y = r[39:38];
    return {x == 2'b11, x == 2'b00, y == 2'b11, y == 2'b00, r[53], r[52], r[44], r[45]};
  endfunction

  function automatic logic [63:0] mk(input logic a, input logic b, input logic st,
                                     input logic se, input logic [1:0] x, input logic [1:0] y);
    logic [63:0] r;
    r = 64'h0;
    r[45] = a; r[44] = b; r[53] = st; r[52] = se;
    r[31:30] = x; r[39:38] = y;
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input int p);
    logic [7:0] b;
    b = m_held[p];
`ifdef USBH_NES_AUTOFIRE_EN
    if (((m_edges / DIV) % 2) == 0) begin
      if (bus.i_autofire_en[2*p])   b[0] = 1'b0;
      if (bus.i_autofire_en[2*p+1]) b[1] = 1'b0;
    end
`endif
    return b;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      m_held[p] = 8'h00; m_chord[p] = 0; m_silent[p] = 0; m_present[p] = 1'b0;
    end
    m_strobe = 1'b0; m_player = 2'd0; m_edges = 0;
  endtask

  task automatic model_step();
    logic acc;
    logic [63:0] r;
    if (rst_n) begin
      m_edges++;
      r   = bus.i_report;
      acc = bus.i_report_valid && (int'(bus.i_report_player) < P);
      m_strobe = acc;
      if (acc) m_player = bus.i_report_player;
      for (int p = 0; p < P; p++) begin
        if (acc && int'(bus.i_report_player) == p) begin
          m_silent[p]  = 0;
          m_present[p] = 1'b1;
          if (r[45] && r[44] && r[53] && r[52]) m_chord[p] = (m_chord[p] + 1 > C) ? C : m_chord[p] + 1;
          else m_chord[p] = 0;
          m_held[p] = ref_decode(r) | ((m_chord[p] >= C) ? 8'hF0 : 8'h00);
        end else if (m_silent[p] < T) begin
          m_silent[p]++;
          if (m_silent[p] == T) begin
            m_held[p] = 8'h00; m_present[p] = 1'b0; m_chord[p] = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model sees the inputs present at the edge, then returns 1 after it
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    bus.i_report_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [1:0] pl, input logic [63:0] r);
    bus.i_report = r; bus.i_report_player = pl; bus.i_report_valid = 1'b1;
    cycle();
    bus.i_report_valid = 1'b0;
  endtask

  // Every-cycle comparison of the DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic [15:0] eb;
        logic [1:0]  ep;
        eb = {exp_byte(1), exp_byte(0)};
        ep = {m_present[1], m_present[0]};
        chk("model_btn", 32'(bus.o_btn), 32'(eb));
        chk("model_strobe", 32'(bus.o_btn_strobe), 32'(m_strobe));
        chk("model_player", 32'(bus.o_btn_player), 32'(m_player));
        chk("model_present", 32'(bus.o_present), 32'(ep));
      end
    end
  end

  initial begin
    bus.i_report = 64'h0; bus.i_report_valid = 1'b0;
    bus.i_report_player = 2'd0; bus.i_autofire_en = 4'b0000;
    model_reset();
    #22;
    rst_n = 1'b1;
    chk("reset_btn", 32'(bus.o_btn), 32'h0);
    chk("reset_present", 32'(bus.o_present), 32'h0);
    chk("reset_strobe", 32'(bus.o_btn_strobe), 32'h0);
    idle(3);

    send(2'd0, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01));
    chk("p0_btn", 32'(bus.o_btn[7:0]), 32'h81);
    chk("p0_strobe", 32'(bus.o_btn_strobe), 32'h1);
    chk("p0_player", 32'(bus.o_btn_player), 32'h0);
    chk("p0_present", 32'(bus.o_present), 32'h1);
    idle(1);
    chk("strobe_single", 32'(bus.o_btn_strobe), 32'h0);

    send(2'd1, mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00));
    chk("p1_btn", 32'(bus.o_btn), 32'h1881);
    chk("p1_player", 32'(bus.o_btn_player), 32'h1);
    chk("p1_present", 32'(bus.o_present), 32'h3);

    send(2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("p3_strobe", 32'(bus.o_btn_strobe), 32'h0);
    chk("p3_btn", 32'(bus.o_btn), 32'h1881);

    send(2'd0, mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01));
    chk("chord1", 32'(bus.o_btn[7:0]), 32'h0F);
    send(2'd0, mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01));
    chk("chord2", 32'(bus.o_btn[7:0]), 32'hFF);
    send(2'd0, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01));
    chk("chord_break", 32'(bus.o_btn[7:0]), 32'h01);
    send(2'd0, mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01));
    chk("chord_cleared", 32'(bus.o_btn[7:0]), 32'h0F);

    bus.i_autofire_en = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      idle(40);
`ifndef USBH_NES_AUTOFIRE_EN
      chk("autofire_off_a", 32'(bus.o_btn[0]), 32'h1);
`endif
    end
    bus.i_autofire_en = 4'b0000;

    send(2'd0, mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01));
    idle(T - 1);
    chk("pre_expiry_present", 32'(bus.o_present[0]), 32'h1);
    chk("pre_expiry_btn", 32'(bus.o_btn[7:0]), 32'h42);
    send(2'd0, mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01));
    chk("expiry_race_present", 32'(bus.o_present[0]), 32'h1);
    idle(T);
    chk("timeout_btn", 32'(bus.o_btn[7:0]), 32'h0);
    chk("timeout_present", 32'(bus.o_present[0]), 32'h0);

    send(2'd1, mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_btn", 32'(bus.o_btn), 32'h0);
    chk("async_rst_strobe", 32'(bus.o_btn_strobe), 32'h0);
    chk("async_rst_present", 32'(bus.o_present), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    chk("post_rst_strobe", 32'(bus.o_btn_strobe), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      if ((i % 64) == 0) bus.i_autofire_en = 4'($urandom_range(0, 15));
      if ((i % 1000) == 999) idle(T + 2);
      bus.i_report = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) bus.i_report = bus.i_report | mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
      bus.i_report_player = 2'($urandom_range(0, 3));
      bus.i_report_valid  = 1'($urandom_range(0, 1));
      cycle();
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
